// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle MIPS main control FSM with memory wait-state timeout (optional ILLEGAL_OPCODE_TRAP_EN)
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic [2:0] alu_op_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_src_o,
    output logic       pc_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       bus_error_o,
    output logic [3:0] state_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        I_EXEC   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        TRAP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;

    state_t     state, nxt;
    logic [7:0] cnt, cnt_n;
    logic [5:0] opc;
    logic       set_err, berr;

    assign bus_error_o = berr;
    assign state_o     = state;

    // state, wait counter, sticky error and opcode latch (opcode captured while in DECODE)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            cnt   <= '0;
            berr  <= 1'b0;
            opc   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
            if (set_err) berr <= 1'b1;
            if (state == DECODE) opc <= opcode_i;
        end
    end

    // next-state and Moore output decode; wait counter only advances while a memory state stalls
    always_comb begin
        nxt          = state;
        cnt_n        = '0;
        set_err      = 1'b0;
        alu_op_o     = 3'b100;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        pc_src_o     = 2'b00;
        pc_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        case (state)
            FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                pc_write_o  = mem_ready_i & reset;
                ir_write_o  = mem_ready_i & reset;
                if (mem_ready_i) nxt = DECODE;
            end
            DECODE: begin
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    OP_R:                 nxt = R_EXEC;
                    OP_ADDI, OP_ORI, OP_LUI: nxt = I_EXEC;
                    OP_LW, OP_SW:         nxt = MEM_ADDR;
                    OP_BEQ, OP_BNE:       nxt = BRANCH;
                    OP_J:                 nxt = JUMP;
                    default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                        nxt     = TRAP;
                        set_err = 1'b1;
`else
                        nxt     = FETCH;
`endif
                    end
                endcase
            end
            R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b111;
                nxt         = ALU_WB;
            end
            I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = (opc == OP_ADDI) ? 2'b10 : 2'b11;
                alu_op_o    = (opc == OP_ADDI) ? 3'b100 : (opc == OP_ORI) ? 3'b101 : 3'b110;
                nxt         = ALU_WB;
            end
            ALU_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (opc == OP_R);
                nxt         = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                nxt         = (opc == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ready_i) nxt = MEM_WB;
            end
            MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                nxt          = FETCH;
            end
            MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) nxt = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 3'b001;
                pc_src_o    = 2'b01;
                pc_write_o  = (opc == OP_BEQ) ? zero_i : ~zero_i;
                nxt         = FETCH;
            end
            JUMP: begin
                pc_src_o   = 2'b10;
                pc_write_o = 1'b1;
                nxt        = FETCH;
            end
            TRAP, HALT: nxt = state;
            default: nxt = FETCH;
        endcase
        if ((state == FETCH || state == MEM_RD || state == MEM_WR) && !mem_ready_i) begin
            if (cnt == 8'(MEM_WAIT_MAX - 1)) begin
                nxt     = HALT;
                set_err = 1'b1;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction stream against a per-instruction cycle model with scoreboard
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode_i = '0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic [2:0] alu_op_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] pc_src_o;
    logic       pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, bus_error_o;
    logic [3:0] state_o;

    multicycle_control_unit #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o),
        .pc_write_o(pc_write_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_write_o(reg_write_o), .bus_error_o(bus_error_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] val;
        logic [20:0] mask;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        berr_m = 1'b0;
    logic [20:0] act;

    assign act = {state_o, alu_op_o, alu_src_a_o, alu_src_b_o, pc_src_o, pc_write_o, i_or_d_o,
                  mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, bus_error_o};

    // expected outputs for one cycle; fields the state does not define are masked out
    function automatic exp_t ex(string n, int st, logic [2:0] aop, logic a, logic [1:0] b, logic [1:0] ps,
                                logic pw, logic iod, logic mr, logic mw, logic irw, logic rd, logic m2r, logic rw);
        exp_t e;
        e.name = n;
        e.val  = {4'(st), aop, a, b, ps, pw, iod, mr, mw, irw, rd, m2r, rw, berr_m};
        e.mask = '1;
        if (!(st inside {0, 1, 2, 6, 7, 9})) e.mask[16:11] = '0;
        if (!(st inside {0, 9, 10})) e.mask[10:9] = '0;
        if (!(st inside {0, 3, 5})) e.mask[7] = 1'b0;
        if (!(st inside {4, 8})) e.mask[2] = 1'b0;
        return e;
    endfunction

    // monitor: compare the DUT against the oldest expectation, mid-cycle
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ((act & e.mask) != (e.val & e.mask)) begin
                failures++;
                $display("FAIL %s: got %h expected %h (mask %h)", e.name, act, e.val, e.mask);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(exp_t e, logic rdy);
        mem_ready_i = rdy;
        sb.push_back(e);
        tick();
    endtask

    task automatic chk(string n, logic ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: state=%0d bus_error=%b mem_read=%b i_or_d=%b wr=%b%b%b%b",
                     n, state_o, bus_error_o, mem_read_o, i_or_d_o,
                     pc_write_o, ir_write_o, mem_write_o, reg_write_o);
        end
    endtask

    task automatic do_reset();
        mem_ready_i = 1'b0;
        reset = 1'b0;
        #1;
        chk("reset_async", state_o == 4'd0 && bus_error_o == 1'b0 && mem_read_o && !i_or_d_o &&
            alu_src_b_o == 2'b01 && !pc_write_o && !ir_write_o && !mem_write_o && !reg_write_o);
        berr_m = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic fetch(int fw);
        for (int i = 0; i < fw; i++) begin
            opcode_i = 6'($urandom);
            cyc(ex("fetch_wait", 0, 3'b100, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
        end
        opcode_i = 6'($urandom);
        cyc(ex("fetch", 0, 3'b100, 0, 2'b01, 2'b00, 1, 0, 1, 0, 1, 0, 0, 0), 1'b1);
    endtask

    task automatic do_instr(logic [5:0] op, logic z, int fw, int mw);
        logic [2:0] aop;
        logic [1:0] b;
        fetch(fw);
        opcode_i = op;
        cyc(ex("decode", 1, 3'b100, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
        opcode_i = 6'($urandom);
        zero_i = 1'($urandom);
        case (op)
            6'h00: begin
                cyc(ex("r_exec", 6, 3'b111, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                cyc(ex("alu_wb_r", 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1), 1'($urandom));
            end
            6'h08, 6'h0d, 6'h0f: begin
                aop = (op == 6'h08) ? 3'b100 : (op == 6'h0d) ? 3'b101 : 3'b110;
                b = (op == 6'h08) ? 2'b10 : 2'b11;
                cyc(ex("i_exec", 7, aop, 1, b, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                cyc(ex("alu_wb_i", 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'($urandom));
            end
            6'h23: begin
                cyc(ex("mem_addr_lw", 2, 3'b100, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                for (int i = 0; i < mw; i++)
                    cyc(ex("mem_rd_wait", 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0);
                cyc(ex("mem_rd", 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b1);
                cyc(ex("mem_wb", 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'($urandom));
            end
            6'h2b: begin
                cyc(ex("mem_addr_sw", 2, 3'b100, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                for (int i = 0; i < mw; i++)
                    cyc(ex("mem_wr_wait", 5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b0);
                cyc(ex("mem_wr", 5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b1);
            end
            6'h04, 6'h05: begin
                zero_i = z;
                cyc(ex((op == 6'h04) ? "branch_beq" : "branch_bne", 9, 3'b001, 1, 2'b00, 2'b01,
                       (op == 6'h04) ? z : !z, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
            end
            6'h02: cyc(ex("jump", 10, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
            default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                berr_m = 1'b1;
                repeat (3) cyc(ex("trap", 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
                do_reset();
`endif
            end
        endcase
    endtask

    logic [5:0] legal [9] = '{6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [5:0] op;
        #2;
        do_reset();
        do_instr(6'h00, 0, 0, 0);
        do_instr(6'h0d, 0, 0, 0);
        do_instr(6'h0f, 0, 0, 0);
        do_instr(6'h23, 0, 0, 3);
        do_instr(6'h2b, 0, 0, 0);
        do_instr(6'h04, 1, 0, 0);
        do_instr(6'h04, 0, 1, 0);
        do_instr(6'h05, 1, 0, 0);
        do_instr(6'h05, 0, 2, 0);
        do_instr(6'h02, 0, 0, 0);
        do_instr(6'h08, 0, 3, 0);
        do_instr(6'h3f, 0, 0, 0);
        do_instr(6'h00, 0, 0, 0);
        repeat (50) begin
            if ($urandom_range(0, 9) == 9) begin
                op = 6'($urandom);
                while (op inside {6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02})
                    op = 6'($urandom);
            end else begin
                op = legal[$urandom_range(0, 8)];
            end
            do_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
        end
        do_instr(6'h2b, 0, 1, 2);
        do_reset();
        for (int i = 0; i < 15; i++)
            cyc(ex("fetch_timeout", 0, 3'b100, 0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0);
        berr_m = 1'b1;
        repeat (3) cyc(ex("halt", 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
        do_reset();
        fetch(0);
        opcode_i = 6'h23;
        cyc(ex("decode_lw", 1, 3'b100, 0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cyc(ex("mem_addr_lw", 2, 3'b100, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cyc(ex("mem_rd_wait", 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0);
        chk("pre_abort_mem_rd", state_o == 4'd3);
        do_reset();
        do_instr(6'h00, 0, 0, 0);
        tick();
        chk("scoreboard_drained", sb.size() == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
